// File: rtl/axis_udp_rx_parse_if.sv
// AXI-Stream bundle used on both sides of the UDP receive parser.
// The master drives the payload and the slave returns tready.
`timescale 1ns/1ps
interface axis_udp_rx_parse_if #(
  parameter int DW = 64
);
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;

  modport master (output tvalid, tlast, tdata, tstrb, input tready);
  modport slave  (input tvalid, tlast, tdata, tstrb, output tready);
endinterface

// File: rtl/axis_udp_rx_parse.sv
// Ethernet/IPv4/UDP receive parser: filters whole frames on MAC, EtherType, IPv4 and port.
// The UDP payload of accepted frames is re-aligned to byte 0 of the master stream.
`timescale 1ns/1ps
module axis_udp_rx_parse #(
  parameter int          AXIS_DATA_WIDTH = 64,
  parameter logic [15:0] LT              = 16'h0800
) (
  input  logic                axis_clk,
  input  logic                axis_s_rst_n,
  axis_udp_rx_parse_if.slave  s_axis,
  axis_udp_rx_parse_if.master m_axis,
  input  logic [47:0]         local_mac_addr,
  input  logic [31:0]         local_ipv4_addr,
  input  logic [15:0]         local_udp_port,
  output logic                hdr_valid,
  output logic [47:0]         hdr_src_mac,
  output logic [31:0]         hdr_src_ip,
  output logic [15:0]         hdr_src_port,
  output logic [15:0]         hdr_udp_len,
  output logic [15:0]         frm_ok_cnt,
  output logic [15:0]         frm_drop_cnt
);

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PASS,
    ST_DROP
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [AXIS_DATA_WIDTH-1:0] w_d;
  logic        w_last;
  logic        w_sReady;
  logic        w_sHs;
  logic        w_mFree;
  logic [3:0]  w_nBytes;
  logic [47:0] w_dstMac;
  logic        w_macOk;
  logic [15:0] w_be16;
  logic [31:0] w_dstIp;
  logic        w_accept;
  logic [7:0]  w_beatStrb;
  logic [7:0]  w_flushStrb;

  logic [2:0]  r_beatCnt;
  logic        r_hdrOk;
  logic [47:0] r_srcMac;
  logic [31:0] r_srcIp;
  logic [15:0] r_dstIpHi;
  logic        r_first;
  logic        r_flush;
  logic [47:0] r_hold;
  logic [2:0]  r_holdN;

  logic                       r_mValid;
  logic [AXIS_DATA_WIDTH-1:0] r_mData;
  logic [7:0]                 r_mStrb;
  logic                       r_mLast;

  logic        r_hdrValid;
  logic [47:0] r_hdrSrcMac;
  logic [31:0] r_hdrSrcIp;
  logic [15:0] r_hdrSrcPort;
  logic [15:0] r_hdrUdpLen;
  logic [15:0] r_okCnt;
  logic [15:0] r_dropCnt;

  assign w_d     = s_axis.tdata;
  assign w_last  = s_axis.tlast;
  assign w_mFree = !r_mValid || m_axis.tready;

  // The input only stalls while passing payload: on output backpressure or a pending flush beat.
  assign w_sReady = (r_state != ST_PASS) || (!r_flush && w_mFree);
  assign w_sHs    = s_axis.tvalid && w_sReady;

  always_comb begin
    w_nBytes = '0;
    for (int i = 0; i < 8; i++) begin
      w_nBytes = w_nBytes + {3'd0, s_axis.tstrb[i]};
    end
  end

  assign w_dstMac = {w_d[7:0], w_d[15:8], w_d[23:16], w_d[31:24], w_d[39:32], w_d[47:40]};
  assign w_macOk  = (w_dstMac == local_mac_addr) || (w_dstMac == 48'hFFFF_FFFF_FFFF);
  // Bytes 4-5 of a beat: EtherType on beat1, destination port on beat4.
  assign w_be16   = {w_d[39:32], w_d[47:40]};
  assign w_dstIp  = {r_dstIpHi, w_d[7:0], w_d[15:8]};
  assign w_accept = r_hdrOk && (w_dstIp == local_ipv4_addr) && (w_be16 == local_udp_port);

  assign w_beatStrb  = (w_nBytes >= 4'd2) ? 8'hFF : ((w_nBytes == 4'd1) ? 8'h7F : 8'h3F);
  assign w_flushStrb = 8'((16'd1 << r_holdN) - 16'd1);

  always_ff @(posedge axis_clk) begin
    if (!axis_s_rst_n) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_HDR: begin
        if (w_sHs && !w_last && (r_beatCnt == 3'd4)) begin
          w_stateNext = w_accept ? ST_PASS : ST_DROP;
        end
      end
      ST_PASS: begin
        if (r_flush) begin
          if (w_mFree) begin
            w_stateNext = ST_HDR;
          end
        end else if (w_sHs && w_last && (w_nBytes <= 4'd2)) begin
          w_stateNext = ST_HDR;
        end
      end
      ST_DROP: begin
        if (w_sHs && w_last) begin
          w_stateNext = ST_HDR;
        end
      end
      default: w_stateNext = ST_HDR;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_s_rst_n) begin
      r_beatCnt    <= '0;
      r_hdrOk      <= 1'b0;
      r_srcMac     <= '0;
      r_srcIp      <= '0;
      r_dstIpHi    <= '0;
      r_first      <= 1'b0;
      r_flush      <= 1'b0;
      r_hold       <= '0;
      r_holdN      <= '0;
      r_mValid     <= 1'b0;
      r_mData      <= '0;
      r_mStrb      <= '0;
      r_mLast      <= 1'b0;
      r_hdrValid   <= 1'b0;
      r_hdrSrcMac  <= '0;
      r_hdrSrcIp   <= '0;
      r_hdrSrcPort <= '0;
      r_hdrUdpLen  <= '0;
      r_okCnt      <= '0;
      r_dropCnt    <= '0;
    end else begin
      r_hdrValid <= 1'b0;
      if (m_axis.tready) begin
        r_mValid <= 1'b0;
      end
      case (r_state)
        ST_HDR: begin
          if (w_sHs) begin
            if (w_last) begin
              r_beatCnt <= '0;
              r_dropCnt <= r_dropCnt + 16'd1;
            end else begin
              r_beatCnt <= (r_beatCnt == 3'd4) ? 3'd0 : r_beatCnt + 3'd1;
              case (r_beatCnt)
                3'd0: begin
                  r_hdrOk         <= w_macOk;
                  r_srcMac[47:32] <= {w_d[55:48], w_d[63:56]};
                end
                3'd1: begin
                  r_hdrOk        <= r_hdrOk && (w_be16 == LT) && (w_d[55:48] == 8'h45);
                  r_srcMac[31:0] <= {w_d[7:0], w_d[15:8], w_d[23:16], w_d[31:24]};
                end
                3'd2: begin
                  r_hdrOk <= r_hdrOk && (w_d[63:56] == 8'h11);
                end
                3'd3: begin
                  r_srcIp   <= {w_d[23:16], w_d[31:24], w_d[39:32], w_d[47:40]};
                  r_dstIpHi <= {w_d[55:48], w_d[63:56]};
                end
                default: begin
                  if (w_accept) begin
                    r_hdrValid   <= 1'b1;
                    r_hdrSrcMac  <= r_srcMac;
                    r_hdrSrcIp   <= r_srcIp;
                    r_hdrSrcPort <= {w_d[23:16], w_d[31:24]};
                    r_hdrUdpLen  <= {w_d[55:48], w_d[63:56]};
                    r_first      <= 1'b1;
                  end else begin
                    r_dropCnt <= r_dropCnt + 16'd1;
                  end
                end
              endcase
            end
          end
        end
        ST_PASS: begin
          if (r_flush) begin
            if (w_mFree) begin
              r_mValid <= 1'b1;
              r_mData  <= {16'd0, r_hold};
              r_mStrb  <= w_flushStrb;
              r_mLast  <= 1'b1;
              r_flush  <= 1'b0;
              r_okCnt  <= r_okCnt + 16'd1;
            end
          end else if (w_sHs) begin
            r_hold  <= w_d[63:16];
            r_holdN <= 3'(w_nBytes - 4'd2);
            if (r_first) begin
              // Beat5 only primes the hold register; its tlast decides flush versus empty payload.
              r_first <= 1'b0;
              if (w_last) begin
                if (w_nBytes > 4'd2) begin
                  r_flush <= 1'b1;
                end else begin
                  r_dropCnt <= r_dropCnt + 16'd1;
                end
              end
            end else begin
              r_mValid <= 1'b1;
              r_mData  <= {w_d[15:0], r_hold};
              r_mStrb  <= w_beatStrb;
              r_mLast  <= w_last && (w_nBytes <= 4'd2);
              if (w_last) begin
                if (w_nBytes > 4'd2) begin
                  r_flush <= 1'b1;
                end else begin
                  r_okCnt <= r_okCnt + 16'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axis.tready = w_sReady;
  assign m_axis.tvalid = r_mValid;
  assign m_axis.tdata  = r_mData;
  assign m_axis.tstrb  = r_mStrb;
  assign m_axis.tlast  = r_mLast;

  assign hdr_valid    = r_hdrValid;
  assign hdr_src_mac  = r_hdrSrcMac;
  assign hdr_src_ip   = r_hdrSrcIp;
  assign hdr_src_port = r_hdrSrcPort;
  assign hdr_udp_len  = r_hdrUdpLen;
  assign frm_ok_cnt   = r_okCnt;
  assign frm_drop_cnt = r_dropCnt;

endmodule
